qar_mem_arbiter: RTL

Shares the single QAR-Core memory port between two requesters: port 0 (core fetch/load-store) and port 1 (debug/DMA). It arbitrates round-robin, sequences one memory transaction at a time through a small FSM, waits the fixed memory read latency, and returns the read data or write acknowledge to the granted requester. It sits between the requesters and the memory model/SRAM.

---
 rtl/qar_mem_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/qar_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the core (port 0) and debug/DMA (port 1).
// One transaction at a time: IDLE -> ISSUE -> (WAIT for reads) -> RESP.
module qar_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_we,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_we,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t            state_r, state_s;
    logic [3:0]        cnt_r, cnt_s;
    logic              last_gnt_r, last_gnt_s;
    logic              win_r, win_s;
    logic              we_r, we_s;
    logic              sel_s;
    logic              load_s;
    logic [DATA_W-1:0] rdata_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_s;

    // On a tie the port that did not win last time gets the port.
    function automatic logic pick_winner(input logic r0, input logic r1, input logic last);
        logic w;
        if (r0 && r1) begin
            w = ~last;
        end else if (r1) begin
            w = 1'b1;
        end else begin
            w = 1'b0;
        end
        return w;
    endfunction

    // Next-state, transaction latch and response-data selection
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        last_gnt_s  = last_gnt_r;
        win_s       = win_r;
        we_s        = we_r;
        load_s      = 1'b0;
        rdata_s     = {DATA_W{1'b0}};
        mem_addr_s  = mem_addr;
        mem_wdata_s = mem_wdata;
        sel_s       = pick_winner(m0_req, m1_req, last_gnt_r);
        case (state_r)
            IDLE: begin
                if (m0_req || m1_req) begin
                    win_s       = sel_s;
                    last_gnt_s  = sel_s;
                    we_s        = sel_s ? m1_we    : m0_we;
                    mem_addr_s  = sel_s ? m1_addr  : m0_addr;
                    mem_wdata_s = sel_s ? m1_wdata : m0_wdata;
                    state_s     = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (we_r) begin
                    // Write acknowledge returns zero data
                    load_s  = 1'b1;
                    state_s = RESP;
                end else begin
                    cnt_s   = LAT_M1;
                    state_s = WAIT;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    load_s  = 1'b1;
                    rdata_s = mem_rdata;
                    state_s = RESP;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, transaction registers and all outputs, decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= 4'd0;
            last_gnt_r <= 1'b1;
            win_r      <= 1'b0;
            we_r       <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= {ADDR_W{1'b0}};
            mem_wdata  <= {DATA_W{1'b0}};
            m0_gnt     <= 1'b0;
            m1_gnt     <= 1'b0;
            m0_rvalid  <= 1'b0;
            m1_rvalid  <= 1'b0;
            m0_rdata   <= {DATA_W{1'b0}};
            m1_rdata   <= {DATA_W{1'b0}};
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            last_gnt_r <= last_gnt_s;
            win_r      <= win_s;
            we_r       <= we_s;
            mem_addr   <= mem_addr_s;
            mem_wdata  <= mem_wdata_s;
            mem_en     <= (state_s == ISSUE);
            mem_we     <= (state_s == ISSUE) && we_s;
            m0_gnt     <= (state_s == ISSUE) && !win_s;
            m1_gnt     <= (state_s == ISSUE) && win_s;
            m0_rvalid  <= (state_s == RESP) && !win_s;
            m1_rvalid  <= (state_s == RESP) && win_s;
            if (load_s && !win_r) begin
                m0_rdata <= rdata_s;
            end
            if (load_s && win_r) begin
                m1_rdata <= rdata_s;
            end
        end
    end

endmodule
